assoc_cache_controller: RTL and testbench

//  Parametrised 2-way set-associative, write-through, LRU cache between the MEM

---
 rtl/assoc_cache_controller_if.sv | 25 ++
 rtl/assoc_cache_controller.sv | 80 ++++++++
 tb/tb_assoc_cache_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/assoc_cache_controller_if.sv
// assoc_cache_controller_if: CPU-side and SRAM-side signals of the cache controller.
interface assoc_cache_controller_if #(parameter int CNT_W = 16);
    logic [31:0]      address;
    logic [31:0]      wdata;
    logic             mem_r_en;
    logic             mem_w_en;
    logic [31:0]      rdata;
    logic             ready;
    logic [31:0]      sram_address;
    logic [31:0]      sram_wdata;
    logic             sram_read;
    logic             sram_write;
    logic [63:0]      sram_rdata;
    logic             sram_ready;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;
    modport slave (
        input  address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_read, sram_write, hit_count, miss_count
    );
    modport master (
        output address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_read, sram_write, hit_count, miss_count
    );
endinterface

// File: rtl/assoc_cache_controller.sv
// assoc_cache_controller: 2-way set-associative, write-through, LRU cache in front of the SRAM controller.
module assoc_cache_controller #(
    parameter int SETS      = 64,
    parameter int BASE_ADDR = 1024,
    parameter int ADDR_W    = 19,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic rst,
    assoc_cache_controller_if.slave cache
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 3 - IDX_W;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;
    state_t           state_q;
    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q [2][SETS];
    logic [63:0]      data_q [2][SETS];
    logic [CNT_W-1:0] hit_count_q, miss_count_q;
    logic [ADDR_W-1:2] a;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit0, hit1, hit, hway, victim, rd_hit, fill, wr_done;
    logic [63:0]      line;
    // The base is 8-byte aligned, so the byte-offset bits never borrow.
    assign a       = cache.address[ADDR_W-1:2] - BASE[ADDR_W-1:2];
    assign idx     = a[3 +: IDX_W];
    assign tag     = a[ADDR_W-1:3+IDX_W];
    assign hit0    = valid_q[0][idx] && tag_q[0][idx] == tag;
    assign hit1    = valid_q[1][idx] && tag_q[1][idx] == tag;
    assign hit     = hit0 || hit1;
    assign hway    = hit1;
    assign line    = hway ? data_q[1][idx] : data_q[0][idx];
    assign victim  = !valid_q[0][idx] ? 1'b0 : !valid_q[1][idx] ? 1'b1 : lru_q[idx];
    assign rd_hit  = state_q == IDLE && cache.mem_r_en && !cache.mem_w_en && hit;
    assign fill    = state_q == RMISS && cache.sram_ready;
    assign wr_done = state_q == WRITE && cache.sram_ready;
    assign cache.rdata = rd_hit ? (a[2] ? line[63:32] : line[31:0]) :
                         fill ? (a[2] ? cache.sram_rdata[63:32] : cache.sram_rdata[31:0]) : '0;
    assign cache.ready = state_q == IDLE ? !(cache.mem_w_en || (cache.mem_r_en && !hit)) : cache.sram_ready;
    assign cache.sram_read    = state_q == RMISS;
    assign cache.sram_write   = state_q == WRITE;
    assign cache.sram_address = state_q != IDLE ? cache.address : '0;
    assign cache.sram_wdata   = state_q == WRITE ? cache.wdata : '0;
    assign cache.hit_count    = hit_count_q;
    assign cache.miss_count   = miss_count_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q[0]   <= '0;
            valid_q[1]   <= '0;
            lru_q        <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q <= state_q == IDLE ? (cache.mem_w_en ? WRITE : (cache.mem_r_en && !hit) ? RMISS : IDLE) :
                       cache.sram_ready ? IDLE : state_q;
            if (rd_hit || (wr_done && hit)) lru_q[idx] <= !hway;
            if (fill) begin
                valid_q[victim][idx] <= 1'b1;
                lru_q[idx]           <= !victim;
            end
            if (rd_hit && !(&hit_count_q)) hit_count_q <= hit_count_q + CNT_W'(1);
            if (fill && !(&miss_count_q)) miss_count_q <= miss_count_q + CNT_W'(1);
        end
    end
    // Tags and data need no reset: they are only looked at behind a valid bit.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[victim][idx]  <= tag;
            data_q[victim][idx] <= cache.sram_rdata;
        end
        if (wr_done && hit) begin
            if (a[2]) data_q[hway][idx][63:32] <= cache.wdata;
            else data_q[hway][idx][31:0] <= cache.wdata;
        end
    end
endmodule

// File: tb/tb_assoc_cache_controller.sv
// tb_assoc_cache_controller: directed checks of hits, misses, LRU eviction, write-through and counters.
module tb_assoc_cache_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int stalls, rd_cyc, wr_cyc;
    logic [31:0] rd, sa, sw;
    always #5 clk = ~clk;
    assoc_cache_controller_if #(.CNT_W(3)) bus ();
    assoc_cache_controller #(.SETS(64), .BASE_ADDR(1024), .ADDR_W(19), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .cache(bus)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    // Issues one request at posedge+1; sram_ready rises once dly stall cycles have elapsed.
    task automatic xact(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] d,
                        input logic [63:0] ln, input int dly);
        bus.mem_r_en = r; bus.mem_w_en = w; bus.address = addr; bus.wdata = d;
        bus.sram_rdata = ln; bus.sram_ready = 1'b0;
        stalls = 0; rd_cyc = 0; wr_cyc = 0; rd = '0; sa = '0; sw = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            rd_cyc += int'(bus.sram_read);
            wr_cyc += int'(bus.sram_write);
            if (bus.ready) begin
                rd = bus.rdata; sa = bus.sram_address; sw = bus.sram_wdata;
                break;
            end
            stalls++;
            @(posedge clk); #1;
            bus.sram_ready = (stalls == dly);
        end
        if (!bus.ready) chk("timeout", 64'(bus.ready), 64'd1);
        @(posedge clk); #1;
        bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0; bus.sram_ready = 1'b0;
    endtask
    initial begin
        bus.address = '0; bus.wdata = '0; bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
        bus.sram_rdata = '0; bus.sram_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_srd", 64'(bus.sram_read), 64'd0);
        chk("rst_swr", 64'(bus.sram_write), 64'd0);
        chk("rst_saddr", 64'(bus.sram_address), 64'd0);
        chk("rst_swdata", 64'(bus.sram_wdata), 64'd0);
        chk("rst_hits", 64'(bus.hit_count), 64'd0);
        chk("rst_miss", 64'(bus.miss_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        xact(1, 0, 32'h400, 0, 64'hBBBB_0002_AAAA_0001, 5);
        chk("miss_stalls", 64'(stalls), 64'd5);
        chk("miss_rdata", 64'(rd), 64'hAAAA0001);
        chk("miss_srd", 64'(rd_cyc), 64'd5);
        chk("miss_cnt1", 64'(bus.miss_count), 64'd1);
        xact(1, 0, 32'h404, 0, 64'h0, 5);
        chk("hit_stalls", 64'(stalls), 64'd0);
        chk("hit_rdata", 64'(rd), 64'hBBBB0002);
        chk("hit_srd", 64'(rd_cyc), 64'd0);
        chk("hit_cnt1", 64'(bus.hit_count), 64'd1);
        @(negedge clk);
        chk("idle_rdata", 64'(bus.rdata), 64'd0);
        chk("idle_ready", 64'(bus.ready), 64'd1);
        @(posedge clk); #1;
        xact(1, 0, 32'h600, 0, 64'h6666_0002_6666_0001, 2);
        chk("fill600", 64'(rd), 64'h66660001);
        xact(1, 0, 32'h800, 0, 64'h8888_0002_8888_0001, 2);
        chk("fill800", 64'(rd), 64'h88880001);
        xact(1, 0, 32'h400, 0, 64'hBBBB_0002_AAAA_0001, 3);
        chk("evict_stalls", 64'(stalls), 64'd3);
        chk("evict_rdata", 64'(rd), 64'hAAAA0001);
        chk("evict_miss", 64'(bus.miss_count), 64'd4);
        xact(1, 0, 32'h800, 0, 64'h0, 2);
        chk("keep800", 64'(rd), 64'h88880001);
        chk("keep800_st", 64'(stalls), 64'd0);
        xact(0, 1, 32'h404, 32'hDEADBEEF, 64'h0, 3);
        chk("wr_stalls", 64'(stalls), 64'd3);
        chk("wr_held", 64'(wr_cyc), 64'd3);
        chk("wr_saddr", 64'(sa), 64'h404);
        chk("wr_sdata", 64'(sw), 64'hDEADBEEF);
        xact(1, 0, 32'h404, 0, 64'h0, 2);
        chk("wrhit_st", 64'(stalls), 64'd0);
        chk("wrhit_rd", 64'(rd), 64'hDEADBEEF);
        chk("wrhit_srd", 64'(rd_cyc), 64'd0);
        xact(1, 0, 32'h400, 0, 64'h0, 2);
        chk("wr_other", 64'(rd), 64'hAAAA0001);
        chk("hit_cnt3", 64'(bus.hit_count), 64'd4);
        xact(1, 1, 32'h404, 32'h12345678, 64'h0, 1);
        chk("rw_srd", 64'(rd_cyc), 64'd0);
        chk("rw_swr", 64'(wr_cyc), 64'd1);
        xact(1, 0, 32'h404, 0, 64'h0, 2);
        chk("rw_rd", 64'(rd), 64'h12345678);
        xact(0, 1, 32'h1000, 32'h5555AAAA, 64'h0, 2);
        xact(1, 0, 32'h1000, 0, 64'h1111_2222_3333_4444, 2);
        chk("noalloc_st", 64'(stalls), 64'd2);
        chk("noalloc_rd", 64'(rd), 64'h33334444);
        chk("noalloc_miss", 64'(bus.miss_count), 64'd5);
        bus.mem_r_en = 1'b1; bus.address = 32'h2000; bus.sram_rdata = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_r_en = 1'b0;
        @(negedge clk);
        chk("mrst_srd", 64'(bus.sram_read), 64'd0);
        chk("mrst_ready", 64'(bus.ready), 64'd1);
        chk("mrst_hits", 64'(bus.hit_count), 64'd0);
        chk("mrst_miss", 64'(bus.miss_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        xact(1, 0, 32'h2000, 0, 64'h2000_0002_2000_0001, 1);
        chk("mrst_again", 64'(stalls), 64'd1);
        chk("mrst_rd", 64'(rd), 64'h20000001);
        xact(1, 0, 32'h400, 0, 64'hBBBB_0002_AAAA_0001, 1);
        chk("mrst_gone", 64'(stalls), 64'd1);
        chk("mrst_cnt", 64'(bus.miss_count), 64'd2);
        for (int k = 0; k < 5; k++) xact(1, 0, 32'h4000 + 32'(k * 8), 0, 64'h0, 1);
        chk("sat_full", 64'(bus.miss_count), 64'd7);
        xact(1, 0, 32'h4028, 0, 64'h0, 1);
        chk("sat_stalls", 64'(stalls), 64'd1);
        chk("sat_hold", 64'(bus.miss_count), 64'd7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
